pipe_stage0_prefetch: RTL and testbench
=======================================

// Module: pipe_stage0_prefetch
// PURPOSE
// - Parametrised fetch stage for JAM-1: feeds the instruction byte stream into pipeline stage 1.
// - Adds a DEPTH-entry prefetch FIFO, so memory fetches continue while downstream stalls (FetchSuppress).
// - Stalled bytes are replayed in order instead of lost. BusRequest (DMA) freezes fetching; Flush (jump) discards.
// - Empty FIFO with no stall gives zero-latency bypass of MemData, the same timing as the unbuffered stage.
// PARAMETERS
// - DATA_W    8      width of fetched word / Pipe0Out
// - DEPTH     4      prefetch FIFO entries (>=2, need not be a power of 2)
// - NOP_VALUE 0      word driven on Pipe0Out when no valid instruction is presented
// - CNT_W     $clog2(DEPTH+1)  width of Count (derived localparam, not overridable)
// PORTS
// - clk                 in   1        rising-edge clock
// - rst                 in   1        asynchronous active-high reset
// - MemData             in   DATA_W   memory read data at PC/RA; valid in the same cycle as FetchEn
// - BusRequest          in   1        DMA owns the bus; no fetch this cycle
// - FetchSuppress       in   1        downstream stall; no word consumed this cycle
// - Flush               in   1        discard all buffered words (taken branch / jump)
// - Flag5_PCRA_Flip     in   1        PC/RA select flag from flags register
// - FetchEn             out  1        fetch accepted this cycle; memory read strobe
// - PcInc               out  1        increment the PC/RA selected by Pipe0Out0_IncPCRA0 (== FetchEn)
// - Pipe0Out            out  DATA_W   instruction word to stage 1
// - Pipe0Valid          out  1        Pipe0Out carries a real instruction (0 => NOP_VALUE bubble)
// - Pipe0Out0_IncPCRA0  out  1        == Flag5_PCRA_Flip (combinational pass-through)
// - Pipe0Out1_IncPCRA1  out  1        == BusRequest (combinational pass-through)
// - Count               out  CNT_W    buffered words, 0..DEPTH
// - Full                out  1        Count == DEPTH
// BEHAVIOUR
// - Reset (async, immediate):
//   - rd_ptr, wr_ptr and Count = 0. FIFO storage is not cleared.
//   - Outputs settle to Pipe0Out = NOP_VALUE, Pipe0Valid = 0, Full = 0.
//   - FetchEn = !BusRequest, so fetching resumes on the first clk edge after rst falls.
// - FetchEn = !Full & !BusRequest & !Flush. Full blocks fetch even when a pop occurs in the same cycle (no pass-through at full).
// - Pop = !FetchSuppress & !Flush & (Count != 0).
// - Output mux (combinational):
//   - FetchSuppress | Flush -> NOP_VALUE, Valid 0.
//   - else Count != 0 -> FIFO head (mem[rd_ptr]), Valid 1.
//   - else FetchEn -> MemData bypass, Valid 1, not stored.
//   - else NOP_VALUE, Valid 0.
// - Push = FetchEn & !bypass; bypass = (Count == 0) & !FetchSuppress.
//   - Pushing with Count != 0 and !FetchSuppress is legal: the head pops and the new word enqueues at the tail.
// - Clock edge:
//   - Flush -> pointers and Count = 0. Overrides push and pop.
//   - else push -> mem[wr_ptr] <= MemData, wr_ptr advances.
//   - pop -> rd_ptr advances.
//   - Count += push - pop. Simultaneous push and pop leaves Count unchanged.
// - Pointers wrap DEPTH-1 -> 0 by explicit compare (non-power-of-2 DEPTH is legal).
// - Ordering: words leave in exactly fetch order. No word is dropped or duplicated except by Flush.
// - Latency: bypass 0 cycles; buffered word leaves >=1 cycle after its fetch.
// - Invariant: Count never exceeds DEPTH and never underflows. Pop at Count == 0 is impossible by construction.
// - BusRequest does not block Pop: buffered words drain during DMA.
// - Reset mid-operation discards the FIFO. PcInc is not driven for the lost words; PC correction is the sequencer's responsibility.
// TESTING
// - Reset, then BusRequest=0, FetchSuppress=0, MemData=8'hA1,A2,A3
//   -> Pipe0Out=A1,A2,A3 in the same cycles, Valid=1, Count stays 0, PcInc=1 each cycle.
// - FetchSuppress=1 for 5 cycles, MemData=10..14 (DEPTH=4)
//   -> Pipe0Out=NOP, Valid=0, Count 1,2,3,4,4, Full after the 4th cycle, FetchEn=0 in the 5th (14 not fetched).
//   -> Release suppress -> outputs 10,11,12,13 in order.
// - Count=2 (buffered 20,21) with BusRequest=1
//   -> FetchEn=0, Pipe0Out1_IncPCRA1=1, outputs 20 then 21, then NOP Valid=0 while BusRequest holds.
// - Count=3 with Flush=1 for 1 cycle
//   -> Pipe0Out=NOP and FetchEn=0 that cycle, Count=0 next cycle, next fetch bypasses.
// - rst asserted mid-clock with Count=3
//   -> Count=0, Valid=0 immediately, without waiting for a clk edge.
// - DEPTH=3 build with a continuous alternating suppress pattern over 50 fetches
//   -> scoreboard confirms in-order, lossless delivery across pointer wrap.

Source files
------------

// File: rtl/pipe_stage0_prefetch.sv
// Fetch stage with a DEPTH-entry prefetch FIFO feeding pipeline stage 1.
// Latency: 0 cycles when the FIFO is empty and there is no stall (MemData bypass); >=1 cycle for buffered words.
// Backpressure: FetchSuppress stalls consumption while fetching continues into the FIFO; Full stops fetching.
module pipe_stage0_prefetch #(
  parameter int               DATA_W    = 8,
  parameter int               DEPTH     = 4,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MemData,
  input  logic              BusRequest,
  input  logic              FetchSuppress,
  input  logic              Flush,
  input  logic              Flag5_PCRA_Flip,
  output logic              FetchEn,
  output logic              PcInc,
  output logic [DATA_W-1:0] Pipe0Out,
  output logic              Pipe0Valid,
  output logic              Pipe0Out0_IncPCRA0,
  output logic              Pipe0Out1_IncPCRA1,
  output logic [CNT_W-1:0]  Count,
  output logic              Full
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_fetch;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // Full blocks fetch even if the head pops this cycle: no pass-through at full.
  assign w_fetch  = !w_full && !BusRequest && !Flush;
  assign w_bypass = w_empty && !FetchSuppress;
  assign w_push   = w_fetch && !w_bypass;
  // BusRequest deliberately absent: buffered words drain during DMA.
  assign w_pop    = !FetchSuppress && !Flush && !w_empty;

  assign FetchEn            = w_fetch;
  assign PcInc              = w_fetch;
  assign Pipe0Out0_IncPCRA0 = Flag5_PCRA_Flip;
  assign Pipe0Out1_IncPCRA1 = BusRequest;
  assign Count              = r_count;
  assign Full               = w_full;

  // Output select: stall/flush bubble, then FIFO head, then live bypass, else bubble.
  always_comb begin
    Pipe0Out   = NOP_VALUE;
    Pipe0Valid = 1'b0;
    if (FetchSuppress || Flush) begin
      Pipe0Out   = NOP_VALUE;
      Pipe0Valid = 1'b0;
    end else if (!w_empty) begin
      Pipe0Out   = r_mem[r_rd_ptr];
      Pipe0Valid = 1'b1;
    end else if (w_fetch) begin
      Pipe0Out   = MemData;
      Pipe0Valid = 1'b1;
    end
  end

  // Storage is not reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= MemData;
    end
  end

  // Pointer and occupancy update; Flush empties the FIFO and overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (Flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_P) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_P) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage0_prefetch.sv
// Bench for pipe_stage0_prefetch: directed scenarios on a DEPTH=4 instance,
// randomized run on DEPTH=4 and DEPTH=3 instances against a queue model.
module tb_pipe_stage0_prefetch;

  localparam logic [7:0] NOP = 8'hEE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_dat = 8'h00;
  logic       bus_req = 1'b0;
  logic       sup = 1'b0;
  logic       flush = 1'b0;
  logic       flag = 1'b0;

  logic       fe    [2];
  logic       pcinc [2];
  logic [7:0] dat   [2];
  logic       vld   [2];
  logic       inc0  [2];
  logic       inc1  [2];
  logic       full  [2];
  logic [2:0] cnt4;
  logic [1:0] cnt3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage0_prefetch #(.DATA_W(8), .DEPTH(4), .NOP_VALUE(NOP)) u_dut4 (
    .clk(clk), .rst(rst), .MemData(mem_dat), .BusRequest(bus_req),
    .FetchSuppress(sup), .Flush(flush), .Flag5_PCRA_Flip(flag),
    .FetchEn(fe[0]), .PcInc(pcinc[0]), .Pipe0Out(dat[0]), .Pipe0Valid(vld[0]),
    .Pipe0Out0_IncPCRA0(inc0[0]), .Pipe0Out1_IncPCRA1(inc1[0]),
    .Count(cnt4), .Full(full[0]));

  pipe_stage0_prefetch #(.DATA_W(8), .DEPTH(3), .NOP_VALUE(NOP)) u_dut3 (
    .clk(clk), .rst(rst), .MemData(mem_dat), .BusRequest(bus_req),
    .FetchSuppress(sup), .Flush(flush), .Flag5_PCRA_Flip(flag),
    .FetchEn(fe[1]), .PcInc(pcinc[1]), .Pipe0Out(dat[1]), .Pipe0Valid(vld[1]),
    .Pipe0Out0_IncPCRA0(inc0[1]), .Pipe0Out1_IncPCRA1(inc1[1]),
    .Count(cnt3), .Full(full[1]));

  function automatic int get_cnt(input int k);
    return (k == 0) ? int'(cnt4) : int'(cnt3);
  endfunction

  task automatic do_reset();
    rst = 1'b1; bus_req = 1'b0; sup = 1'b0; flush = 1'b0; mem_dat = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_req = 1'b1;
    #2;
    total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt4); end
    total++; if (vld[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vld[0]); end
    total++; if (dat[0] !== NOP) begin bad++; $display("FAIL reset_out got=%h want=%h", dat[0], NOP); end
    total++; if (full[0] !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full[0]); end
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL reset_fetchen_busreq got=%b want=0", fe[0]); end
    bus_req = 1'b0;
    #1;
    total++; if (fe[0] !== 1'b1) begin bad++; $display("FAIL reset_fetchen got=%b want=1", fe[0]); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    logic [7:0] words [3];
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_dat = words[i];
      @(negedge clk);
      total++; if (dat[0] !== words[i] || vld[0] !== 1'b1) begin bad++; $display("FAIL bypass_out[%0d] got=%h/%b want=%h/1", i, dat[0], vld[0], words[i]); end
      total++; if (pcinc[0] !== 1'b1) begin bad++; $display("FAIL bypass_pcinc[%0d] got=%b want=1", i, pcinc[0]); end
      step();
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL bypass_count[%0d] got=%0d want=0", i, cnt4); end
    end
  endtask

  task automatic test_suppress_fill();
    int want_cnt;
    logic [7:0] want;
    do_reset();
    sup = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_dat = 8'h10 + 8'(i);
      @(negedge clk);
      total++; if (dat[0] !== NOP || vld[0] !== 1'b0) begin bad++; $display("FAIL fill_out[%0d] got=%h/%b want=%h/0", i, dat[0], vld[0], NOP); end
      total++; if (fe[0] !== (i < 4)) begin bad++; $display("FAIL fill_fetchen[%0d] got=%b want=%b", i, fe[0], (i < 4)); end
      step();
      want_cnt = (i + 1 > 4) ? 4 : i + 1;
      total++; if (int'(cnt4) !== want_cnt) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, cnt4, want_cnt); end
      total++; if (full[0] !== (want_cnt == 4)) begin bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full[0], (want_cnt == 4)); end
    end
    sup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_dat = 8'h30 + 8'(i);
      want = 8'h10 + 8'(i);
      @(negedge clk);
      total++; if (dat[0] !== want || vld[0] !== 1'b1) begin bad++; $display("FAIL drain_out[%0d] got=%h/%b want=%h/1", i, dat[0], vld[0], want); end
      step();
    end
  endtask

  task automatic test_busreq_drain();
    logic [7:0] want_d [4];
    logic       want_v [4];
    want_d[0] = 8'h20; want_d[1] = 8'h21; want_d[2] = NOP; want_d[3] = NOP;
    want_v[0] = 1'b1;  want_v[1] = 1'b1;  want_v[2] = 1'b0; want_v[3] = 1'b0;
    do_reset();
    sup = 1'b1;
    mem_dat = 8'h20; step();
    mem_dat = 8'h21; step();
    total++; if (cnt4 !== 3'd2) begin bad++; $display("FAIL dma_prefill_count got=%0d want=2", cnt4); end
    sup = 1'b0; bus_req = 1'b1; mem_dat = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (fe[0] !== 1'b0 || inc1[0] !== 1'b1) begin bad++; $display("FAIL dma_fetch[%0d] got=fe%b/inc1%b want=fe0/inc11", i, fe[0], inc1[0]); end
      total++; if (dat[0] !== want_d[i] || vld[0] !== want_v[i]) begin bad++; $display("FAIL dma_out[%0d] got=%h/%b want=%h/%b", i, dat[0], vld[0], want_d[i], want_v[i]); end
      step();
    end
    bus_req = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    sup = 1'b1;
    for (int i = 0; i < 3; i++) begin mem_dat = 8'h40 + 8'(i); step(); end
    total++; if (cnt4 !== 3'd3) begin bad++; $display("FAIL flush_prefill got=%0d want=3", cnt4); end
    sup = 1'b0; flush = 1'b1; mem_dat = 8'h4F;
    @(negedge clk);
    total++; if (dat[0] !== NOP || vld[0] !== 1'b0 || fe[0] !== 1'b0) begin bad++; $display("FAIL flush_cycle got=%h/%b/fe%b want=%h/0/fe0", dat[0], vld[0], fe[0], NOP); end
    step();
    total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", cnt4); end
    flush = 1'b0; mem_dat = 8'h50;
    @(negedge clk);
    total++; if (dat[0] !== 8'h50 || vld[0] !== 1'b1) begin bad++; $display("FAIL flush_bypass got=%h/%b want=50/1", dat[0], vld[0]); end
    step();
    total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL flush_bypass_count got=%0d want=0", cnt4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    sup = 1'b1;
    for (int i = 0; i < 3; i++) begin mem_dat = 8'h60 + 8'(i); step(); end
    sup = 1'b0; bus_req = 1'b1;
    #1;
    total++; if (cnt4 !== 3'd3 || vld[0] !== 1'b1 || dat[0] !== 8'h60) begin bad++; $display("FAIL areset_pre got=%0d/%b/%h want=3/1/60", cnt4, vld[0], dat[0]); end
    rst = 1'b1;
    #1;
    total++; if (cnt4 !== 3'd0 || vld[0] !== 1'b0 || dat[0] !== NOP) begin bad++; $display("FAIL areset_immediate got=%0d/%b/%h want=0/0/%h", cnt4, vld[0], dat[0], NOP); end
    step();
    rst = 1'b0; bus_req = 1'b0;
  endtask

  // Randomized run on both depths; model is a queue of buffered words.
  task automatic test_random();
    logic [7:0] q [2][$];
    int         depth [2];
    logic       e_fe, e_v;
    logic [7:0] e_d;
    bit         from_q;
    int         delivered = 0;
    depth[0] = 4; depth[1] = 3;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      mem_dat = 8'($urandom);
      bus_req = ($urandom_range(0, 7) == 0);
      sup     = cyc[0] ^ ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 39) == 0);
      flag    = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e_fe = (q[k].size() < depth[k]) && !bus_req && !flush;
        from_q = 1'b0;
        if (sup || flush) begin e_d = NOP; e_v = 1'b0; end
        else if (q[k].size() > 0) begin e_d = q[k][0]; e_v = 1'b1; from_q = 1'b1; end
        else if (e_fe) begin e_d = mem_dat; e_v = 1'b1; end
        else begin e_d = NOP; e_v = 1'b0; end
        total++; if (dat[k] !== e_d || vld[k] !== e_v) begin bad++; $display("FAIL rnd_out d%0d cyc%0d got=%h/%b want=%h/%b", depth[k], cyc, dat[k], vld[k], e_d, e_v); end
        total++; if (fe[k] !== e_fe || pcinc[k] !== e_fe) begin bad++; $display("FAIL rnd_fetch d%0d cyc%0d got=%b/%b want=%b", depth[k], cyc, fe[k], pcinc[k], e_fe); end
        total++; if (get_cnt(k) !== q[k].size() || full[k] !== (q[k].size() == depth[k])) begin bad++; $display("FAIL rnd_count d%0d cyc%0d got=%0d/%b want=%0d", depth[k], cyc, get_cnt(k), full[k], q[k].size()); end
        total++; if (inc0[k] !== flag || inc1[k] !== bus_req) begin bad++; $display("FAIL rnd_pass d%0d cyc%0d got=%b%b want=%b%b", depth[k], cyc, inc0[k], inc1[k], flag, bus_req); end
        if (k == 1 && e_v) delivered++;
        if (flush) begin
          q[k].delete();
        end else begin
          if (from_q) void'(q[k].pop_front());
          if (e_fe && !(e_v && !from_q)) q[k].push_back(mem_dat);
        end
      end
      step();
    end
    total++; if (delivered < 50) begin bad++; $display("FAIL rnd_delivered got=%0d want>=50", delivered); end
    bus_req = 1'b0; sup = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_suppress_fill();
    test_busreq_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
